// File: rtl/qa_driver_csr_rd_pkg.sv
// Shared types and constants for the QA driver status-register read responder.
package qa_driver_csr_rd_pkg;

    typedef logic [31:0] t_sreg_addr;
    typedef logic [63:0] t_sreg;

    localparam t_sreg       SREG_TIMEOUT_VAL    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DSM_SREG_OFFSET_DEF = 64'd1;

    typedef logic [2:0] t_csr_rd_state;
    localparam t_csr_rd_state ST_IDLE     = 3'd0;
    localparam t_csr_rd_state ST_REQ      = 3'd1;
    localparam t_csr_rd_state ST_WAIT_RSP = 3'd2;
    localparam t_csr_rd_state ST_SEND     = 3'd3;
    localparam t_csr_rd_state ST_WAIT_ACK = 3'd4;

    // Response line: value in the low quadword, then address, then sequence number.
    function automatic logic [511:0] build_rsp_line(input t_sreg value,
                                                    input logic [31:0] addr,
                                                    input logic [31:0] seq);
        build_rsp_line = {384'd0, seq, addr, value};
    endfunction

endpackage

// File: rtl/qa_driver_csr_rd_if.sv
// Status-source fetch and c1 write-channel signals of the status-register read responder.
interface qa_driver_csr_rd_if #(
    parameter int SREG_ADDR_W = 32
);
    logic                   sreg_req_valid;
    logic [SREG_ADDR_W-1:0] sreg_req_addr;
    logic                   sreg_rsp_valid;
    logic [63:0]            sreg_rsp_data;
    logic                   c1_tx_almfull;
    logic                   c1_tx_valid;
    logic [63:0]            c1_tx_addr;
    logic [511:0]           c1_tx_data;
    logic [15:0]            c1_tx_mdata;
    logic                   c1_rx_wr_ack;
    logic [15:0]            c1_rx_mdata;

    modport master (
        output sreg_req_valid, sreg_req_addr,
        input  sreg_rsp_valid, sreg_rsp_data,
        input  c1_tx_almfull,
        output c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata,
        input  c1_rx_wr_ack, c1_rx_mdata
    );

    modport slave (
        input  sreg_req_valid, sreg_req_addr,
        output sreg_rsp_valid, sreg_rsp_data,
        output c1_tx_almfull,
        input  c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata,
        output c1_rx_wr_ack, c1_rx_mdata
    );
endinterface

// File: rtl/qa_driver_csr_rd.sv
// Status-register read responder: fetches a status value on a CSR request and
// writes it, with address and sequence number, to the DSM response line over c1.
module qa_driver_csr_rd
    import qa_driver_csr_rd_pkg::*;
#(
    parameter int          SREG_ADDR_W     = 32,
    parameter logic [63:0] DSM_SREG_OFFSET = DSM_SREG_OFFSET_DEF,
    parameter int          RSP_TIMEOUT     = 255,
    parameter logic [15:0] MDATA_TAG       = 16'h5352
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   csr_sreg_req_en,
    input  logic [SREG_ADDR_W-1:0] csr_sreg_req_addr,
    input  logic [63:0]            csr_dsm_base,
    input  logic                   csr_dsm_base_valid,
    qa_driver_csr_rd_if.master     bus,
    output logic                   busy,
    output logic                   err_drop
);

    localparam int TMR_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(RSP_TIMEOUT);

    t_csr_rd_state          state_r;
    t_csr_rd_state          state_nxt_s;
    logic [TMR_W-1:0]       timer_r;
    logic [31:0]            seq_r;
    logic [63:0]            base_r;
    logic [SREG_ADDR_W-1:0] sreg_req_addr_r;
    logic                   sreg_req_valid_r;
    logic                   c1_tx_valid_r;
    logic [63:0]            c1_tx_addr_r;
    logic [511:0]           c1_tx_data_r;
    logic [15:0]            c1_tx_mdata_r;
    logic                   busy_r;
    logic                   err_drop_r;
    logic                   accept_s;
    logic                   rsp_done_s;
    t_sreg                  rsp_value_s;
    logic                   issue_s;
    logic                   ack_done_s;

    // Next-state decode; the write is issued straight from WAIT_RSP when c1 has room.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        rsp_done_s  = 1'b0;
        rsp_value_s = SREG_TIMEOUT_VAL;
        issue_s     = 1'b0;
        ack_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (csr_sreg_req_en && csr_dsm_base_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_nxt_s = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                // Real data wins over a timeout in the same cycle.
                if (bus.sreg_rsp_valid) begin
                    rsp_done_s  = 1'b1;
                    rsp_value_s = bus.sreg_rsp_data;
                end else if (timer_r == TMR_MAX) begin
                    rsp_done_s  = 1'b1;
                    rsp_value_s = SREG_TIMEOUT_VAL;
                end else begin
                    rsp_done_s  = 1'b0;
                end
                if (rsp_done_s && !bus.c1_tx_almfull) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ST_WAIT_ACK;
                end else if (rsp_done_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_WAIT_RSP;
                end
            end
            ST_SEND: begin
                if (!bus.c1_tx_almfull) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ST_WAIT_ACK;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.c1_rx_wr_ack && (bus.c1_rx_mdata == MDATA_TAG)) begin
                    ack_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            timer_r          <= '0;
            seq_r            <= 32'd0;
            base_r           <= 64'd0;
            sreg_req_addr_r  <= '0;
            sreg_req_valid_r <= 1'b0;
            c1_tx_valid_r    <= 1'b0;
            c1_tx_addr_r     <= 64'd0;
            c1_tx_data_r     <= 512'd0;
            c1_tx_mdata_r    <= 16'd0;
            busy_r           <= 1'b0;
            err_drop_r       <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            busy_r           <= (state_nxt_s != ST_IDLE);
            err_drop_r       <= csr_sreg_req_en && ((state_r != ST_IDLE) || !csr_dsm_base_valid);
            sreg_req_valid_r <= accept_s;
            c1_tx_valid_r    <= issue_s;
            if (accept_s) begin
                sreg_req_addr_r <= csr_sreg_req_addr;
                base_r          <= csr_dsm_base;
            end
            if (state_r == ST_WAIT_RSP) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= '0;
            end
            // Line is frozen here and held through SEND and WAIT_ACK.
            if (rsp_done_s) begin
                c1_tx_data_r  <= build_rsp_line(rsp_value_s, 32'(sreg_req_addr_r), seq_r);
                c1_tx_addr_r  <= base_r + DSM_SREG_OFFSET;
                c1_tx_mdata_r <= MDATA_TAG;
            end
            if (ack_done_s) begin
                seq_r <= seq_r + 32'd1;
            end
        end
    end

    assign bus.sreg_req_valid = sreg_req_valid_r;
    assign bus.sreg_req_addr  = sreg_req_addr_r;
    assign bus.c1_tx_valid    = c1_tx_valid_r;
    assign bus.c1_tx_addr     = c1_tx_addr_r;
    assign bus.c1_tx_data     = c1_tx_data_r;
    assign bus.c1_tx_mdata    = c1_tx_mdata_r;
    assign busy               = busy_r;
    assign err_drop           = err_drop_r;

endmodule
